// File: rtl/ysyx_23060286_seq.sv
// Multi-cycle instruction sequencer: fetch, execute, optional memory access, writeback.
// Drives IFU/LSU handshakes, gates PC/IR/RF writes, and flags halt and error conditions.
module ysyx_23060286_seq #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             ifu_req_valid,
  input  logic             ifu_req_ready,
  input  logic             ifu_rsp_valid,
  output logic             ifu_rsp_ready,
  output logic             inst_we,
  input  logic [6:0]       op,
  input  logic             dec_regwrite,
  output logic             lsu_req_valid,
  input  logic             lsu_req_ready,
  output logic             lsu_wen,
  input  logic             lsu_rsp_valid,
  output logic             rf_we,
  output logic             pc_we,
  output logic             halt,
  output logic             err,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IF_REQ   = 3'd0,
    S_IF_WAIT  = 3'd1,
    S_EX       = 3'd2,
    S_MEM_REQ  = 3'd3,
    S_MEM_WAIT = 3'd4,
    S_WB       = 3'd5,
    S_HALT     = 3'd6,
    S_ERR      = 3'd7
  } state_t;

  localparam int WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = (TIMEOUT > 0) ? WCW'(TIMEOUT - 1) : '0;

  state_t             state_reg;
  logic [WCW-1:0]     wait_cnt_reg;
  logic               lsu_wen_reg;
  logic [CNT_W-1:0]   instret_reg;
  logic               in_wait;
  logic               hs;
  logic               timed_out;
  logic               op_alu;

  // hs is the handshake that lets the current wait state exit
  always_comb begin
    in_wait = 1'b0;
    hs      = 1'b0;
    case (state_reg)
      S_IF_REQ:   begin in_wait = 1'b1; hs = ifu_req_ready; end
      S_IF_WAIT:  begin in_wait = 1'b1; hs = ifu_rsp_valid; end
      S_MEM_REQ:  begin in_wait = 1'b1; hs = lsu_req_ready; end
      S_MEM_WAIT: begin in_wait = 1'b1; hs = lsu_rsp_valid; end
      default:    begin in_wait = 1'b0; hs = 1'b0; end
    endcase
  end

  assign timed_out = (TIMEOUT > 0) && in_wait && !hs && (wait_cnt_reg == WAIT_LAST);

  assign op_alu = (op == 7'd19) || (op == 7'd51) || (op == 7'd55) || (op == 7'd23) ||
                  (op == 7'd99) || (op == 7'd111) || (op == 7'd103);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IF_REQ;
      wait_cnt_reg <= '0;
      lsu_wen_reg  <= 1'b0;
      instret_reg  <= '0;
    end else begin
      // counter restarts whenever the state changes or a non-wait state is held
      if (in_wait && !hs && !timed_out)
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
      else
        wait_cnt_reg <= '0;

      case (state_reg)
        S_IF_REQ: begin
          if (hs)             state_reg <= S_IF_WAIT;
          else if (timed_out) state_reg <= S_ERR;
        end
        S_IF_WAIT: begin
          if (hs)             state_reg <= S_EX;
          else if (timed_out) state_reg <= S_ERR;
        end
        S_EX: begin
          if (op == 7'd3) begin
            lsu_wen_reg <= 1'b0;
            state_reg   <= S_MEM_REQ;
          end else if (op == 7'd35) begin
            lsu_wen_reg <= 1'b1;
            state_reg   <= S_MEM_REQ;
          end else if (op == 7'd115) begin
            state_reg   <= S_HALT;
          end else if (op_alu) begin
            lsu_wen_reg <= 1'b0;
            state_reg   <= S_WB;
          end else begin
            state_reg   <= S_ERR;
          end
        end
        S_MEM_REQ: begin
          if (hs)             state_reg <= S_MEM_WAIT;
          else if (timed_out) state_reg <= S_ERR;
        end
        S_MEM_WAIT: begin
          if (hs)             state_reg <= S_WB;
          else if (timed_out) state_reg <= S_ERR;
        end
        S_WB: begin
          instret_reg <= instret_reg + 1'b1;
          state_reg   <= S_IF_REQ;
        end
        S_HALT:  state_reg <= S_HALT;
        S_ERR:   state_reg <= S_ERR;
        default: state_reg <= S_ERR;
      endcase
    end
  end

  // strobes are forced low while reset is held, even though state already reads IF_REQ
  assign ifu_req_valid = rst_n && (state_reg == S_IF_REQ);
  assign ifu_rsp_ready = rst_n && (state_reg == S_IF_WAIT);
  assign inst_we       = rst_n && (state_reg == S_IF_WAIT) && ifu_rsp_valid;
  assign lsu_req_valid = rst_n && (state_reg == S_MEM_REQ);
  assign pc_we         = rst_n && (state_reg == S_WB);
  assign rf_we         = rst_n && (state_reg == S_WB) && dec_regwrite && !lsu_wen_reg &&
                         (op != 7'd35) && (op != 7'd99);
  assign lsu_wen       = lsu_wen_reg;
  assign halt          = (state_reg == S_HALT);
  assign err           = (state_reg == S_ERR);
  assign instret       = instret_reg;
  assign state         = state_reg;

endmodule
